// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO drained back-to-back onto tx_serial.
// Latency: start bit on the line 2 cycles after an accepted write into an idle, empty block.
// Backpressure: full while FIFO_DEPTH bytes are queued; writes while full are dropped and set sticky overflow.
//
// Ports:
//   ICE_CLK, RST        clock, synchronous active-high reset
//   wr_en, wr_byte      write strobe and data (sampled only when accepted)
//   full, level         FIFO status (level is 0..FIFO_DEPTH)
//   overflow            sticky dropped-write flag, cleared only by RST
//   tx_serial           UART line, idle high
//   tx_busy, tx_done    frame on the line / one-cycle end-of-frame pulse

// Generic single-clock FIFO, registered pointers and occupancy.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module uart_tx_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [AW:0]      level,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage is not reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
  assign full     = (level == (AW+1)'(DEPTH));

endmodule

module uart_tx_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int UART_BAUD  = 9600,
  parameter int FIFO_DEPTH = 16,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic          ICE_CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  logic [7:0]    wr_byte,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overflow,
  output logic          tx_serial,
  output logic          tx_busy,
  output logic          tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / UART_BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          launch;     // head already popped in IDLE, START follows next edge
  logic [7:0]    head_byte;
  logic          wr_accept;
  logic          fifo_empty;
  logic          bit_end;
  logic          stop_end;
  logic          bypass;     // write on the final stop cycle into an empty FIFO goes straight to the shifter
  logic          fifo_push;
  logic          fifo_pop;

  assign wr_accept  = wr_en && !full;
  assign fifo_empty = (level == '0);
  assign bit_end    = (baud_cnt == LAST_CNT);
  assign stop_end   = (state == STOP) && bit_end;
  assign bypass     = stop_end && fifo_empty && wr_accept;
  assign fifo_push  = wr_accept && !bypass;
  assign fifo_pop   = ((state == IDLE) && !launch && !fifo_empty) || (stop_end && !fifo_empty);

  uart_tx_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk      (ICE_CLK),
    .rst      (RST),
    .push     (fifo_push),
    .push_dat (wr_byte),
    .pop      (fifo_pop),
    .head_dat (head_byte),
    .level    (level),
    .full     (full)
  );

  always_ff @(posedge ICE_CLK) begin
    if (RST) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      launch    <= 1'b0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      // full is the pre-pop value, so a same-cycle pop does not rescue the write
      if (wr_en && full) overflow <= 1'b1;

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (launch) begin
            launch    <= 1'b0;
            state     <= START;
            tx_serial <= 1'b0;
            tx_busy   <= 1'b1;
          end else if (!fifo_empty) begin
            shift  <= head_byte;
            launch <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            tx_serial <= shift[0];
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_serial <= 1'b1;
              state     <= STOP;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx_serial <= shift[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            tx_done  <= 1'b1;
            if (!fifo_empty) begin
              shift     <= head_byte;
              tx_serial <= 1'b0;
              state     <= START;
            end else if (bypass) begin
              shift     <= wr_byte;
              tx_serial <= 1'b0;
              state     <= START;
            end else begin
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered 8N1 UART transmitter. It is the transmit end of the board's serial link, which carries 9600-baud traffic between ICE_CLK logic and the host. Bytes are written into a small synchronous FIFO. A bit-timing state machine drains the FIFO onto the serial line back-to-back, so producers such as the echo path from uart_rx can push bursts without waiting per byte.

Parameters:
CLK_FREQ, 12000000, ICE_CLK frequency in Hz.
UART_BAUD, 9600, line rate. CLKS_PER_BIT = CLK_FREQ/UART_BAUD (integer divide; must be ≥ 2).
FIFO_DEPTH, 16, byte entries. Must be a power of two, ≥ 2. AW = log2(FIFO_DEPTH).

Ports:
ICE_CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous reset, active-high.
wr_en  input  1  write strobe; pushes wr_byte when not full.
wr_byte  input  8  data to enqueue.
full  output  1  FIFO holds FIFO_DEPTH entries.
level  output  AW+1  current FIFO occupancy, 0..FIFO_DEPTH.
overflow  output  1  sticky; set when wr_en is asserted while full.
tx_serial  output  1  UART line, idle high.
tx_busy  output  1  high while a frame is on the line (START/DATA/STOP).
tx_done  output  1  one-cycle pulse after each frame's stop bit completes.

Behaviour:
- Reset (RST=1 at an edge):
  - tx_serial=1, tx_busy=0, tx_done=0, full=0, level=0, overflow=0.
  - FIFO is flushed and the FSM goes to IDLE.
  - A frame in progress is aborted; the line is high from the cycle after reset.
- FIFO:
  - Write accepted iff wr_en && !full; stored at that edge, so level increments the next cycle.
  - A write while full is dropped and sets overflow, which clears only on RST. This applies even if a pop occurs the same cycle; full is evaluated before the pop.
  - Simultaneous accepted write and pop: level unchanged, order preserved.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - full = (level == FIFO_DEPTH).
- FSM states: IDLE, START, DATA, STOP. Baud counter runs 0..CLKS_PER_BIT-1; bit index runs 0..7.
- IDLE:
  - tx_serial=1, tx_busy=0.
  - If level≠0: pop the head into the shift register and go to START at the next edge.
- START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx_serial = shift[bit index], LSB first, each bit held CLKS_PER_BIT cycles.
  - After bit 7, go to STOP.
- STOP: tx_serial=1 for CLKS_PER_BIT cycles.
  - On the final stop cycle, if level≠0 (write visible at that edge counts), pop and go directly to START; otherwise go to IDLE.
  - tx_done pulses for the one cycle following the final stop cycle, in either case.
- Timing:
  - Back-to-back frames are exactly 10*CLKS_PER_BIT cycles apart, with no idle gap.
  - Latency from an accepted write into an empty FIFO with the FSM in IDLE: the start bit appears on tx_serial 2 cycles after the wr_en edge.
    - Edge 0: store.
    - Edge 1: IDLE sees level=1 and pops.
    - Edge 2: START is registered and tx_serial=0.
- tx_serial, tx_busy and tx_done are registered outputs, glitch-free.
- wr_byte is sampled only on accepted writes. Later changes do not affect queued data.

Test Plan:
All scenarios use CLK_FREQ=8, UART_BAUD=1 (CLKS_PER_BIT=8) and FIFO_DEPTH=4.
1. Single byte: write 0x41 from idle.
   - tx_serial low 2 cycles after the write edge.
   - Then bits 1,0,0,0,0,0,1,0 (LSB first) for 8 cycles each, then high for 8 cycles.
   - tx_done pulses once, 80 cycles after the start bit began; tx_busy drops with it.
2. Burst: write 0x55, 0xAA, 0x0F, 0xF0 on consecutive cycles.
   - full=1 after the 4th write is stored, unless the first pop has already occurred.
   - Frames appear back-to-back with start edges exactly 80 cycles apart.
   - 4 tx_done pulses; level returns to 0.
3. Overflow: fill to level=4 while the line is held in START by the first frame, then write 0x99.
   - 0x99 is never transmitted; overflow=1 stays set.
   - level stays 4 that cycle.
4. Write during last stop cycle: write 0x3C on the final STOP cycle of a frame with an otherwise empty FIFO.
   - Next START begins the following cycle; no IDLE gap.
   - 0x3C is transmitted correctly.
5. Reset mid-frame: assert RST for 1 cycle during DATA bit 3 with 2 bytes queued.
   - tx_serial=1, level=0, tx_busy=0 the next cycle; overflow cleared.
   - No further frames; a fresh write of 0x7E afterwards transmits normally.
6. Pointer wrap: write and drain 10 sequential bytes 0x00..0x09 with at most 3 outstanding.
   - All received in order by a bench-side 8N1 decoder; overflow stays 0.
